// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: access sizes, writeback selects,
// the transaction FSM states and the default data width.
package mem_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_COUT = 2'b10,
    WB_FWD  = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_WAIT_GNT    = 2'b01,
    ST_WAIT_RVALID = 2'b10,
    ST_HOLD        = 2'b11
  } mem_state_t;

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane logic for a 32-bit data memory: store byte enables and lane
// replication, load lane extraction with sign/zero extension, misalignment.
module mem_stage_align #(
  parameter int XLEN = mem_stage_pkg::XLEN
) (
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);
  import mem_stage_pkg::*;

  mem_size_t  sz;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign sz     = mem_size_t'(size);
  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (sz)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {{(XLEN-8){1'b0}}, lane_b}
                                : {{(XLEN-8){lane_b[7]}}, lane_b};
      end
      SIZE_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_data  = is_unsigned ? {{(XLEN-16){1'b0}}, lane_h}
                                 : {{(XLEN-16){lane_h[15]}}, lane_h};
        misaligned = addr_lo[0];
      end
      // Size 2'b11 is not a legal encoding; it is treated as a word.
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage and MEM/WB register: one data-memory transaction per
// load/store over req/gnt/rvalid, stalling upstream while it is outstanding.
module mem_stage #(
  parameter int XLEN       = mem_stage_pkg::XLEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  input  logic [XLEN-1:0]       addr_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic [XLEN-1:0]       result_i,
  input  logic [XLEN-1:0]       cout_i,
  input  logic [XLEN-1:0]       forward_data_i,
  input  logic                  forward_en_i,
  input  logic                  reg_write_enable_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [XLEN-1:0]       dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  stall_o,
  output logic [XLEN-1:0]       result_o,
  output logic [XLEN-1:0]       mem_data_o,
  output logic [XLEN-1:0]       cout_o,
  output logic [XLEN-1:0]       forward_data_o,
  output logic                  forward_en_o,
  output logic                  reg_write_enable_o,
  output logic                  valid_o,
  output logic [1:0]            wb_sel_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  misaligned_o,
  output logic [1:0]            state_o
);
  import mem_stage_pkg::*;

  typedef struct packed {
    logic                  valid;
    logic                  read;
    logic                  write;
    logic [1:0]            size;
    logic                  is_unsigned;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       store_data;
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       cout;
    logic [XLEN-1:0]       fwd;
    logic                  fwd_en;
    logic                  rwe;
    wb_sel_t               wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } inst_t;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       mem_data;
    logic [XLEN-1:0]       cout;
    logic [XLEN-1:0]       fwd;
    logic                  fwd_en;
    logic                  rwe;
    logic                  valid;
    wb_sel_t               wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } wb_t;

  function automatic wb_t to_wb(inst_t i, logic [XLEN-1:0] md);
    wb_t w;
    w.result   = i.result;
    w.mem_data = md;
    w.cout     = i.cout;
    w.fwd      = i.fwd;
    w.fwd_en   = i.fwd_en;
    w.rwe      = i.rwe;
    w.valid    = i.valid;
    w.wb_sel   = i.wb_sel;
    w.rd       = i.rd;
    return w;
  endfunction

  mem_state_t      state, state_next;
  logic            kill_q, kill_next;
  inst_t           in_inst, inst_q, cur;
  wb_t             wb_q, wb_next;
  logic            wb_load, hold_load, mis_next, mis_q;
  logic [XLEN-1:0] hold_q;
  logic            is_mem, mis_op, req, stall;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, load_data;
  logic            misaligned;

  always_comb begin
    in_inst.valid       = valid_i;
    in_inst.read        = mem_read_i;
    in_inst.write       = mem_write_i;
    in_inst.size        = mem_size_i;
    in_inst.is_unsigned = mem_unsigned_i;
    in_inst.addr        = addr_i;
    in_inst.store_data  = store_data_i;
    in_inst.result      = result_i;
    in_inst.cout        = cout_i;
    in_inst.fwd         = forward_data_i;
    in_inst.fwd_en      = forward_en_i;
    in_inst.rwe         = reg_write_enable_i;
    in_inst.wb_sel      = wb_sel_t'(wb_sel_i);
    in_inst.rd          = rd_i;
  end

  // Outside IDLE the accepted instruction is replayed from inst_q, which keeps
  // the request fields stable until gnt regardless of what upstream presents.
  assign cur    = (state == ST_IDLE) ? in_inst : inst_q;
  assign is_mem = cur.valid & (cur.read | cur.write);
  assign mis_op = is_mem & misaligned;

  mem_stage_align #(.XLEN(XLEN)) u_align (
    .size        (cur.size),
    .is_unsigned (cur.is_unsigned),
    .addr_lo     (cur.addr[1:0]),
    .store_data  (cur.store_data),
    .rdata       (dmem_rdata_i),
    .be          (be),
    .wdata       (wdata),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  // Next state, MEM/WB load enable and handshake outputs. Killed transactions
  // always finish their handshake and then write a bubble, even under stall_i.
  always_comb begin
    state_next = state;
    kill_next  = kill_q;
    wb_load    = 1'b0;
    wb_next    = to_wb(cur, '0);
    hold_load  = 1'b0;
    mis_next   = 1'b0;
    req        = 1'b0;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        kill_next = 1'b0;
        if (flush_i) begin
          wb_load = 1'b1;
          wb_next = '0;
        end else if (!is_mem || mis_op) begin
          wb_load     = !stall_i;
          wb_next.rwe = cur.rwe & !mis_op;
          mis_next    = mis_op & !stall_i;
        end else begin
          req = 1'b1;
          if (!dmem_gnt_i) begin
            stall      = 1'b1;
            state_next = ST_WAIT_GNT;
          end else if (cur.read) begin
            stall      = 1'b1;
            state_next = ST_WAIT_RVALID;
          end else if (stall_i) begin
            state_next = ST_HOLD;
          end else begin
            wb_load = 1'b1;
          end
        end
      end
      ST_WAIT_GNT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (flush_i) kill_next = 1'b1;
        if (dmem_gnt_i) begin
          if (cur.read) begin
            state_next = ST_WAIT_RVALID;
          end else begin
            stall      = 1'b0;
            kill_next  = 1'b0;
            state_next = ST_IDLE;
            if (kill_q || flush_i) begin
              wb_load = 1'b1;
              wb_next = '0;
            end else if (stall_i) begin
              state_next = ST_HOLD;
            end else begin
              wb_load = 1'b1;
            end
          end
        end
      end
      ST_WAIT_RVALID: begin
        stall = !dmem_rvalid_i;
        if (flush_i) kill_next = 1'b1;
        if (dmem_rvalid_i) begin
          kill_next  = 1'b0;
          state_next = ST_IDLE;
          if (kill_q || flush_i) begin
            wb_load = 1'b1;
            wb_next = '0;
          end else if (stall_i) begin
            hold_load  = 1'b1;
            state_next = ST_HOLD;
          end else begin
            wb_load          = 1'b1;
            wb_next.mem_data = load_data;
          end
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          wb_load    = 1'b1;
          wb_next    = '0;
          state_next = ST_IDLE;
        end else if (!stall_i) begin
          wb_load          = 1'b1;
          wb_next.mem_data = cur.read ? hold_q : '0;
          state_next       = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= ST_IDLE;
      kill_q <= 1'b0;
      inst_q <= '0;
      wb_q   <= '0;
      mis_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      state  <= state_next;
      kill_q <= kill_next;
      mis_q  <= mis_next;
      if (state == ST_IDLE) inst_q <= in_inst;
      if (wb_load) wb_q <= wb_next;
      if (hold_load) hold_q <= load_data;
    end
  end

  // IDLE drives the request straight from the inputs, so reset must gate it.
  assign dmem_req_o   = req & rst_n_i;
  assign stall_o      = stall & rst_n_i;
  assign dmem_we_o    = dmem_req_o & cur.write;
  assign dmem_addr_o  = dmem_req_o ? {cur.addr[XLEN-1:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
  assign dmem_wdata_o = dmem_req_o ? wdata : '0;

  assign result_o           = wb_q.result;
  assign mem_data_o         = wb_q.mem_data;
  assign cout_o             = wb_q.cout;
  assign forward_data_o     = wb_q.fwd;
  assign forward_en_o       = wb_q.fwd_en;
  assign reg_write_enable_o = wb_q.rwe;
  assign valid_o            = wb_q.valid;
  assign wb_sel_o           = wb_q.wb_sel;
  assign rd_o               = wb_q.rd;
  assign misaligned_o       = mis_q;
  assign state_o            = state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-transaction vectors plus
// hand-written sequences for delayed grant, flush, HOLD and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i, flush_i, valid_i, mem_read_i, mem_write_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [31:0] addr_i, store_data_i, result_i, cout_i, forward_data_i;
  logic        forward_en_i, reg_write_enable_i;
  logic [1:0]  wb_sel_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic [31:0] result_o, mem_data_o, cout_o, forward_data_o;
  logic        forward_en_o, reg_write_enable_o, valid_o;
  logic [1:0]  wb_sel_o;
  logic [4:0]  rd_o;
  logic        misaligned_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .result_i(result_i), .cout_i(cout_i),
    .forward_data_i(forward_data_i), .forward_en_i(forward_en_i),
    .reg_write_enable_i(reg_write_enable_i), .wb_sel_i(wb_sel_i), .rd_i(rd_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .result_o(result_o), .mem_data_o(mem_data_o), .cout_o(cout_o),
    .forward_data_o(forward_data_o), .forward_en_o(forward_en_o),
    .reg_write_enable_o(reg_write_enable_o), .valid_o(valid_o),
    .wb_sel_o(wb_sel_o), .rd_o(rd_o), .misaligned_o(misaligned_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; mem_size_i = 2'b00;
    mem_unsigned_i = 1'b0; addr_i = '0; store_data_i = '0; result_i = '0;
    cout_i = '0; forward_data_i = '0; forward_en_i = 1'b0;
    reg_write_enable_i = 1'b0; wb_sel_i = 2'b00; rd_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    flush_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] result, input logic [4:0] rd, input logic rwe);
    valid_i = 1'b1; mem_read_i = rd_en; mem_write_i = wr_en; mem_size_i = size;
    mem_unsigned_i = uns; addr_i = addr; store_data_i = sdata; result_i = result;
    cout_i = ~result; forward_data_i = result ^ 32'h0F0F_0F0F; forward_en_i = 1'b0;
    reg_write_enable_i = rwe; wb_sel_i = rd_en ? 2'd1 : 2'd0; rd_i = rd;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mem;
    logic        exp_rwe;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  initial begin
    int stall_cnt;
    logic [31:0] exp_md;

    vecs[0]  = '{"lw_word",  1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'hDEADBEEF, 1'b1, 4'hF, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1]  = '{"lb_sext",  1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h000000EE, 32'h80112233, 1'b1, 4'h8, 32'hEEEEEEEE, 32'hFFFFFF80, 1'b1, 1'b0};
    vecs[2]  = '{"lbu_zext", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h000000EE, 32'h80112233, 1'b1, 4'h8, 32'hEEEEEEEE, 32'h00000080, 1'b1, 1'b0};
    vecs[3]  = '{"lb_lane1", 1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h00000011, 32'h80112233, 1'b1, 4'h2, 32'h11111111, 32'h00000022, 1'b1, 1'b0};
    vecs[4]  = '{"lh_sext",  1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h00005678, 32'h80112233, 1'b1, 4'hC, 32'h56785678, 32'hFFFF8011, 1'b1, 1'b0};
    vecs[5]  = '{"lhu_low",  1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h00005678, 32'h80118233, 1'b1, 4'h3, 32'h56785678, 32'h00008233, 1'b1, 1'b0};
    vecs[6]  = '{"lh_low",   1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h00000000, 32'h80118233, 1'b1, 4'h3, 32'h00000000, 32'hFFFF8233, 1'b1, 1'b0};
    vecs[7]  = '{"sb",       1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h000000A5, 32'h0,        1'b1, 4'h4, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{"sw",       1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0,        1'b1, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{"sh_low",   1'b0, 1'b1, 2'b01, 1'b0, 32'h100, 32'h00001234, 32'h0,        1'b1, 4'h3, 32'h12341234, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{"alu_op",   1'b0, 1'b0, 2'b10, 1'b0, 32'h055, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[11] = '{"lw_mis",   1'b1, 1'b0, 2'b10, 1'b0, 32'h202, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[12] = '{"lh_mis",   1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[13] = '{"sw_mis",   1'b0, 1'b1, 2'b10, 1'b0, 32'h10A, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};

    // Reset state
    drive_idle();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_rwe", reg_write_enable_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_state", state_o, ST_IDLE);
    next_cycle();
    rst_n_i = 1'b1;
    next_cycle();

    // Table-driven single transactions: gnt in the request cycle, rvalid next.
    for (int i = 0; i < NVEC; i++) begin
      vec_t v;
      v = vecs[i];
      drive_op(v.rd_en, v.wr_en, v.size, v.uns, v.addr, v.sdata, 32'h1000 + i, 5'(i + 1), !v.wr_en);
      wb_sel_i = 2'(i % 4);
      forward_en_i = i[0];
      dmem_gnt_i = v.exp_req;
      dmem_rdata_i = v.rdata;
      exp_q.push_back(v.exp_mem);
      @(negedge clk_i);
      chk({v.name, "_req"}, dmem_req_o, v.exp_req);
      chk({v.name, "_stall0"}, stall_o, v.rd_en & v.exp_req);
      if (v.exp_req) begin
        chk({v.name, "_be"}, dmem_be_o, v.exp_be);
        chk({v.name, "_wdata"}, dmem_wdata_o, v.exp_wdata);
        chk({v.name, "_addr"}, dmem_addr_o, v.addr & 32'hFFFF_FFFC);
        chk({v.name, "_we"}, dmem_we_o, v.wr_en);
      end
      next_cycle();
      if (v.rd_en && v.exp_req) begin
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        @(negedge clk_i);
        chk({v.name, "_stall1"}, stall_o, 0);
        next_cycle();
      end
      drive_idle();
      @(negedge clk_i);
      exp_md = exp_q.pop_front();
      chk({v.name, "_mem_data"}, mem_data_o, exp_md);
      chk({v.name, "_rwe"}, reg_write_enable_o, v.exp_rwe);
      chk({v.name, "_valid"}, valid_o, 1);
      chk({v.name, "_rd"}, rd_o, 32'(i + 1));
      chk({v.name, "_wb_sel"}, wb_sel_o, 32'(i % 4));
      chk({v.name, "_result"}, result_o, 32'h1000 + i);
      chk({v.name, "_cout"}, cout_o, ~(32'h1000 + i));
      chk({v.name, "_fwd"}, forward_data_o, (32'h1000 + i) ^ 32'h0F0F_0F0F);
      chk({v.name, "_fwd_en"}, forward_en_o, 32'(i % 2));
      chk({v.name, "_mis"}, misaligned_o, v.exp_mis);
      next_cycle();
      @(negedge clk_i);
      chk({v.name, "_mis_pulse"}, misaligned_o, 0);
      next_cycle();
    end

    // SH 0x102 with gnt in the fourth request cycle: three stall cycles.
    drive_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h77, 5'd7, 1'b0);
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      dmem_gnt_i = (c == 3);
      @(negedge clk_i);
      chk("sh_wait_req", dmem_req_o, 1);
      chk("sh_wait_be", dmem_be_o, 4'b1100);
      chk("sh_wait_wdata", dmem_wdata_o, 32'hABCDABCD);
      chk("sh_wait_addr", dmem_addr_o, 32'h100);
      if (stall_o) stall_cnt++;
      next_cycle();
    end
    drive_idle();
    @(negedge clk_i);
    chk("sh_stall_cycles", 32'(stall_cnt), 3);
    chk("sh_done_req", dmem_req_o, 0);
    chk("sh_done_rd", rd_o, 7);
    chk("sh_done_result", result_o, 32'h77);
    next_cycle();

    // LW killed in WAIT_RVALID; rvalid two cycles after the flush.
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 32'h88, 5'd9, 1'b1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("kill_stall0", stall_o, 1);
    next_cycle();
    drive_idle();
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("kill_stall1", stall_o, 1);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("kill_stall2", stall_o, 1);
    chk("kill_no_req", dmem_req_o, 0);
    next_cycle();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h11111111;
    @(negedge clk_i);
    chk("kill_stall3", stall_o, 0);
    next_cycle();
    drive_idle();
    @(negedge clk_i);
    chk("kill_valid", valid_o, 0);
    chk("kill_rwe", reg_write_enable_o, 0);
    chk("kill_state", state_o, ST_IDLE);
    next_cycle();

    // Non-mem hold under stall_i, then flush overriding stall_i.
    drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hAAAA0001, 5'd3, 1'b1);
    next_cycle();
    result_i = 32'hAAAA0002;
    stall_i = 1'b1;
    next_cycle();
    @(negedge clk_i);
    chk("stall_hold_result", result_o, 32'hAAAA0001);
    chk("stall_hold_valid", valid_o, 1);
    flush_i = 1'b1;
    next_cycle();
    @(negedge clk_i);
    chk("flush_bubble_valid", valid_o, 0);
    chk("flush_bubble_rwe", reg_write_enable_o, 0);
    drive_idle();
    next_cycle();

    // rvalid while stall_i=1 parks the data in HOLD until stall_i drops.
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 32'h99, 5'd10, 1'b1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    next_cycle();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h0BADF00D;
    stall_i = 1'b1;
    @(negedge clk_i);
    chk("hold_stall_rvalid", stall_o, 0);
    next_cycle();
    dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("hold_state", state_o, ST_HOLD);
    chk("hold_mem_data_old", mem_data_o, 0);
    chk("hold_no_req", dmem_req_o, 0);
    next_cycle();
    stall_i = 1'b0;
    @(negedge clk_i);
    chk("hold_release_no_req", dmem_req_o, 0);
    next_cycle();
    drive_idle();
    @(negedge clk_i);
    chk("hold_mem_data", mem_data_o, 32'h0BADF00D);
    chk("hold_rd", rd_o, 10);
    chk("hold_rwe", reg_write_enable_o, 1);
    next_cycle();

    // Asynchronous reset while a load waits for rvalid.
    drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h5A5A5A5A, 5'd4, 1'b1);
    next_cycle();
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h120, 32'h0, 32'h66, 5'd5, 1'b1);
    dmem_gnt_i = 1'b1;
    next_cycle();
    dmem_gnt_i = 1'b0;
    #2;
    chk("prerst_state", state_o, ST_WAIT_RVALID);
    chk("prerst_result", result_o, 32'h5A5A5A5A);
    rst_n_i = 1'b0;
    #1;
    chk("arst_result", result_o, 0);
    chk("arst_valid", valid_o, 0);
    chk("arst_rwe", reg_write_enable_o, 0);
    chk("arst_rd", rd_o, 0);
    chk("arst_req", dmem_req_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_state", state_o, ST_IDLE);
    next_cycle();
    drive_idle();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_state", state_o, ST_IDLE);
    chk("post_rst_req", dmem_req_o, 0);
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
